// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS main control FSM:
// opcodes, functs, ALU control codes, mux selects and the fixed state encoding.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JEX    = 4'd11,
    S_HALT   = 4'd15
  } state_e;

  // Which ALU-control rule the current state uses
  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_RTYPE = 2'd1,
    CLS_BEQ   = 2'd2,
    CLS_IMM   = 2'd3
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU-control and extender-select decode from Op/Funct,
// steered by the class of the current FSM state.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  cls_e       cls_i,
  output logic [2:0] alu_ctl_o,
  output logic       ext_op_o,
  output logic       funct_valid_o
);

  always_comb begin
    funct_valid_o = 1'b0;
    case (funct_i)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_valid_o = 1'b1;
      default: funct_valid_o = 1'b0;
    endcase
  end

  // andi/ori are logical ops on a zero-extended immediate; everything else sign-extends
  always_comb begin
    alu_ctl_o = ALU_ADD;
    ext_op_o  = 1'b1;
    case (cls_i)
      CLS_RTYPE: begin
        case (funct_i)
          FN_SUB:  alu_ctl_o = ALU_SUB;
          FN_AND:  alu_ctl_o = ALU_AND;
          FN_OR:   alu_ctl_o = ALU_OR;
          FN_SLT:  alu_ctl_o = ALU_SLT;
          default: alu_ctl_o = ALU_ADD;
        endcase
      end
      CLS_BEQ: alu_ctl_o = ALU_SUB;
      CLS_IMM: begin
        case (op_i)
          OP_ANDI: begin
            alu_ctl_o = ALU_AND;
            ext_op_o  = 1'b0;
          end
          OP_ORI: begin
            alu_ctl_o = ALU_OR;
            ext_op_o  = 1'b0;
          end
          default: begin
            alu_ctl_o = ALU_ADD;
            ext_op_o  = 1'b1;
          end
        endcase
      end
      default: begin
        alu_ctl_o = ALU_ADD;
        ext_op_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore main control FSM for the multi-cycle MIPS datapath, with a
// request/ready handshake on the shared memory port.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               MemReq,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUCtl,
  output logic               ExtOp,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] State
);

  state_e     state_q, state_d;
  logic       illegal_q;
  cls_e       cls;
  logic [2:0] aluCtl;
  logic       extOp, functValid;
  logic       memReq, memWrite, iorD, irWrite, pcWrite;
  logic       regDst, memtoReg, regWrite, aluSrcA;
  logic [1:0] pcSrc, aluSrcB;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_HALT) illegal_q <= 1'b1;
    end
  end

  // IMMWB keeps the IMMEX class so ExtOp/ALUCtl stay stable into writeback
  always_comb begin
    cls = CLS_NONE;
    case (state_q)
      S_RTEX:           cls = CLS_RTYPE;
      S_BEQEX:          cls = CLS_BEQ;
      S_IMMEX, S_IMMWB: cls = CLS_IMM;
      default:          cls = CLS_NONE;
    endcase
  end

  alu_decoder u_alu_decoder (
    .op_i          (Op),
    .funct_i       (Funct),
    .cls_i         (cls),
    .alu_ctl_o     (aluCtl),
    .ext_op_o      (extOp),
    .funct_valid_o (functValid)
  );

  always_comb begin
    state_d  = state_q;
    memReq   = 1'b0;
    memWrite = 1'b0;
    iorD     = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = PCSRC_ALU;
    regDst   = 1'b0;
    memtoReg = 1'b0;
    regWrite = 1'b0;
    aluSrcA  = 1'b0;
    aluSrcB  = SRCB_RT;
    case (state_q)
      S_FETCH: begin
        memReq  = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = MemReady;
        pcWrite = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = SRCB_IMMSH;
        case (Op)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_RTYPE:                 state_d = functValid ? S_RTEX : S_HALT;
          OP_BEQ:                   state_d = S_BEQEX;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          OP_J:                     state_d = S_JEX;
          default:                  state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memReq = 1'b1;
        iorD   = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_RTEX: begin
        aluSrcA = 1'b1;
        state_d = S_RTWB;
      end
      S_RTWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX: begin
        aluSrcA = 1'b1;
        pcSrc   = PCSRC_ALUOUT;
        pcWrite = Zero;
        state_d = S_FETCH;
      end
      S_IMMEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JEX: begin
        pcSrc   = PCSRC_JUMP;
        pcWrite = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Every output is forced low while reset is held, not just the registered ones
  assign MemReq    = Rst_n & memReq;
  assign MemWrite  = Rst_n & memWrite;
  assign IorD      = Rst_n & iorD;
  assign IRWrite   = Rst_n & irWrite;
  assign PCWrite   = Rst_n & pcWrite;
  assign PCSrc     = Rst_n ? pcSrc : 2'b00;
  assign RegDst    = Rst_n & regDst;
  assign MemtoReg  = Rst_n & memtoReg;
  assign RegWrite  = Rst_n & regWrite;
  assign ALUSrcA   = Rst_n & aluSrcA;
  assign ALUSrcB   = Rst_n ? aluSrcB : 2'b00;
  assign ALUCtl    = Rst_n ? aluCtl : 3'b000;
  assign ExtOp     = Rst_n & extOp;
  assign IllegalOp = Rst_n & illegal_q;
  assign State     = STATE_W'(state_q);

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode, execute, memory and writeback over a shared ALU and a single memory port.
- Drives every datapath mux and write-enable, including ExtOp, the sign/zero-extension select for the immediate extender.
- Sits between the instruction register (Op/Funct inputs) and the datapath.
- Stalls on a ready/request handshake with the memory port.

Parameters:
- STATE_W, 4, width of the state register and the State debug port.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Op  input  6  IR[31:26]
- Funct  input  6  IR[5:0]
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory port has completed the current access this cycle
- MemReq  output  1  memory access request, held until MemReady
- MemWrite  output  1  1 = write access (qualifies MemReq)
- IorD  output  1  0 = address from PC, 1 = address from ALUOut
- IRWrite  output  1  load IR
- PCWrite  output  1  load PC (already combines the branch condition)
- PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- RegDst  output  1  0 = rt, 1 = rd
- MemtoReg  output  1  0 = ALUOut, 1 = MDR
- RegWrite  output  1  register-file write enable
- ALUSrcA  output  1  0 = PC, 1 = rs
- ALUSrcB  output  2  00 = rt, 01 = constant 4, 10 = extended immediate, 11 = extended immediate shifted left 2
- ALUCtl  output  3  AND 000, OR 001, ADD 010, SUB 110, SLT 111
- ExtOp  output  1  1 = sign-extend, 0 = zero-extend
- IllegalOp  output  1  sticky; set on an unsupported Op or Funct
- State  output  STATE_W  current state, for debug

Behaviour:
- Reset:
  - Rst_n low forces State = FETCH asynchronously, even mid-instruction.
  - While Rst_n is low, all outputs are 0, including MemReq and IllegalOp.
  - The first active cycle after deassertion is FETCH.
- Any output not listed for a state is 0. ALUCtl defaults to ADD and ExtOp defaults to 1.
- FETCH:
  - Outputs: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtl=ADD, PCSrc=00.
  - IRWrite and PCWrite equal MemReady (combinational), so both assert only in the completing cycle.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUCtl=ADD, ExtOp=1 (precomputes the branch target).
  - Next state by Op:
    - 100011 (lw) / 101011 (sw) -> MEMADR
    - 000000 (R-type) -> RTEX
    - 000100 (beq) -> BEQEX
    - 001000 (addi) / 001100 (andi) / 001101 (ori) -> IMMEX
    - 000010 (j) -> JEX
    - any other Op -> HALT
  - An R-type with Funct not in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} -> HALT.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUCtl=ADD. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemReq=1, IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, then FETCH.
- MEMWR: MemReq=1, MemWrite=1, IorD=1. Waits for MemReady, then FETCH.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUCtl from Funct decode, then RTWB.
- RTWB: RegWrite=1, RegDst=1, MemtoReg=0, then FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, ALUCtl=SUB, PCSrc=01, PCWrite=Zero. Then FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10. ExtOp=1 and ALUCtl=ADD for addi; ExtOp=0 with AND/OR for andi/ori. Then IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0. ExtOp and ALUCtl are held at their IMMEX values. Then FETCH.
- JEX: PCSrc=10, PCWrite=1, then FETCH.
- HALT:
  - IllegalOp is set on entry and the state is terminal until reset.
  - No memory, register or PC writes occur.
- Latency in cycles, with zero-wait memory: R-type 4, addi/andi/ori 4, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.
- MemReady outside a MemReq state is ignored.
- MemReq stays asserted and all address selects stay stable until MemReady.
- State encoding is fixed for debug: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, IMMEX 9, IMMWB 10, JEX 11, HALT 15.

Decomposition:
- Shared package holds opcode constants, funct constants, ALUCtl codes, the state encoding, and the PCSrc/ALUSrcB codes.
- One combinational sub-module, alu_decoder: Op, Funct, state class -> ALUCtl, ExtOp, FunctValid.

Test Plan:
- Reset mid-MEMRD (Rst_n low for 1 cycle) -> State=0 immediately, all outputs 0; FETCH MemReq=1 after release.
- add (Op 000000, Funct 100000), MemReady always 1 -> states 0,1,6,7,0; RTWB has RegWrite=1, RegDst=1; RTEX has ALUCtl=010.
- lw with MemReady low for 3 cycles in MEMRD -> MemReq=1 and IorD=1 held for 4 cycles, then MEMWB with MemtoReg=1; 8 cycles total.
- beq with Zero=1, then again with Zero=0 -> PCWrite=1 with PCSrc=01 in BEQEX for Zero=1; PCWrite=0 for Zero=0.
- ori (001101) -> IMMEX has ExtOp=0, ALUCtl=001, ALUSrcB=10. addi -> ExtOp=1, ALUCtl=010.
- Op 111111, and R-type Funct 000111 -> State=15, IllegalOp=1 sticky, no RegWrite/PCWrite/MemReq until reset.
